// File: rtl/reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_arbiter
// Description : Round-robin arbiter granting NREQ requesters one at a time
//               onto a shared 8-bit register bus with configurable read latency.
// Revision    : 1.0
// ============================================================================
module reg_arbiter #(
    parameter int NREQ     = 3,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic [7:0]        reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              reg_wr,
    output logic              reg_rd
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam logic [1:0] C_LAST_WAIT  = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);
    localparam logic [1:0] C_RST_GRANT  = 2'(NREQ - 1);
    localparam logic [NREQ-1:0] C_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [3:0]  w_req_ext;
    logic        w_found;
    logic [1:0]  w_pick;
    logic [1:0]  w_cand;
    logic        w_pick_wr;
    logic [7:0]  w_pick_addr;
    logic [7:0]  w_pick_wdata;

    // Search starts one past the last grant so a persistent requester yields.
    always_comb begin
        w_req_ext    = 4'(req);
        w_found      = 1'b0;
        w_pick       = grant_q;
        w_cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = 2'((int'(grant_q) + k) % NREQ);
            if (!w_found && w_req_ext[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
        w_pick_wr    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == 2'(i)) begin
                w_pick_wr    = req_wr[i];
                w_pick_addr  = req_addr[8*i +: 8];
                w_pick_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d = w_pick;
                    wr_d    = w_pick_wr;
                    addr_d  = w_pick_addr;
                    wdata_d = w_pick_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                cnt_d = '0;
                if (wr_q) begin
                    state_d = ST_ACK;
                end else if (READ_LAT == 0) begin
                    rdata_d = reg_rdata;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == C_LAST_WAIT) begin
                    rdata_d = reg_rdata;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= C_RST_GRANT;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes and ack decode from the state alone, so reset clears them at once.
    always_comb begin
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        ack    = '0;
        case (state_q)
            ST_STROBE: begin
                reg_wr = wr_q;
                reg_rd = !wr_q;
            end
            ST_ACK:  ack = C_ONE << grant_q;
            default: ;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_arbiter
// Description : Directed self-checking bench for reg_arbiter (READ_LAT 1 and 0).
// Revision    : 1.0
// ============================================================================
module tb_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [2:0]  req = '0, req_wr = '0;
    logic [23:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  ack;
    logic [7:0]  rdata, reg_addr, reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;
    logic        busy, reg_wr, reg_rd;
    logic [1:0]  grant_id;

    logic [2:0]  req_z = '0, req_wr_z = '0;
    logic [23:0] req_addr_z = '0, req_wdata_z = '0;
    logic [2:0]  ack_z;
    logic [7:0]  rdata_z, reg_addr_z, reg_wdata_z, reg_rdata_z;
    logic        busy_z, reg_wr_z, reg_rd_z;
    logic [1:0]  grant_id_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_arbiter #(.NREQ(3), .READ_LAT(1)) dut (
        .clk(clk), .reset(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
        .grant_id(grant_id), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_wr(reg_wr), .reg_rd(reg_rd)
    );

    reg_arbiter #(.NREQ(3), .READ_LAT(0)) dut_z (
        .clk(clk), .reset(rst), .req(req_z), .req_wr(req_wr_z), .req_addr(req_addr_z),
        .req_wdata(req_wdata_z), .ack(ack_z), .rdata(rdata_z), .busy(busy_z),
        .grant_id(grant_id_z), .reg_addr(reg_addr_z), .reg_wdata(reg_wdata_z),
        .reg_rdata(reg_rdata_z), .reg_wr(reg_wr_z), .reg_rd(reg_rd_z)
    );

    // Register model: one-cycle latency, data present only in the cycle after reg_rd.
    always @(posedge clk)
        reg_rdata <= reg_rd ? ((reg_addr == 8'h05) ? 8'h3C : (reg_addr ^ 8'h5A)) : 8'h00;

    // Zero-latency model: data valid only while the strobe is high.
    assign reg_rdata_z = (reg_rd_z && reg_addr_z == 8'hFF) ? 8'h81 : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_grant", grant_id, 2);
        chk("rst_wr", reg_wr, 0);
        chk("rst_rd", reg_rd, 0);
        tick();
        tick();
        rst = 1'b0;

        // Read, requester 0, addr 0x05, READ_LAT=1
        req = 3'b001; req_wr = 3'b000; req_addr[7:0] = 8'h05;
        chk("rd_c0_busy", busy, 0);
        tick();
        chk("rd_c1_grant", grant_id, 0);
        chk("rd_c1_busy", busy, 1);
        chk("rd_c1_addr", reg_addr, 8'h05);
        chk("rd_c1_rd", reg_rd, 0);
        tick();
        chk("rd_c2_rd", reg_rd, 1);
        chk("rd_c2_wr", reg_wr, 0);
        tick();
        chk("rd_c3_rd", reg_rd, 0);
        chk("rd_c3_ack", ack, 0);
        tick();
        chk("rd_c4_ack", ack, 3'b001);
        chk("rd_c4_rdata", rdata, 8'h3C);
        req = 3'b000;
        tick();
        chk("rd_c5_ack", ack, 0);
        chk("rd_c5_busy", busy, 0);

        // Write, requester 1, addr 0x12 data 0xA5
        req = 3'b010; req_wr = 3'b010; req_addr[15:8] = 8'h12; req_wdata[15:8] = 8'hA5;
        tick();
        chk("wr_c1_grant", grant_id, 1);
        chk("wr_c1_addr", reg_addr, 8'h12);
        chk("wr_c1_wdata", reg_wdata, 8'hA5);
        chk("wr_c1_wr", reg_wr, 0);
        chk("wr_c1_busy", busy, 1);
        tick();
        chk("wr_c2_wr", reg_wr, 1);
        chk("wr_c2_busy", busy, 1);
        tick();
        chk("wr_c3_ack", ack, 3'b010);
        chk("wr_c3_wr", reg_wr, 0);
        chk("wr_c3_rdata", rdata, 8'h3C);
        req = 3'b000;
        tick();
        chk("wr_c4_busy", busy, 0);
        chk("wr_c4_addr", reg_addr, 8'h12);

        // Round robin with all three holding write requests from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111; req_wr = 3'b111;
        req_addr = {8'h22, 8'h21, 8'h20}; req_wdata = {8'hC2, 8'hC1, 8'hC0};
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_grant", grant_id, n % 3);
            chk("rr_addr", reg_addr, 8'h20 + n % 3);
            tick();
            chk("rr_wr", reg_wr, 1);
            tick();
            chk("rr_ack", ack, 32'(1) << (n % 3));
            tick();
            chk("rr_idle", busy, 0);
        end
        req = 3'b000;
        tick();

        // Requester 0 drops req in SETUP and changes its address
        req = 3'b011; req_wr = 3'b011;
        tick();
        chk("drop_grant0", grant_id, 0);
        req = 3'b010; req_addr[7:0] = 8'h99;
        tick();
        chk("drop_addr_held", reg_addr, 8'h20);
        tick();
        chk("drop_ack0", ack, 3'b001);
        tick();
        tick();
        chk("drop_grant1", grant_id, 1);
        tick();
        tick();
        chk("drop_ack1", ack, 3'b010);
        req = 3'b000;
        tick();

        // Reset during WAIT of a read by requester 2
        req = 3'b100; req_wr = 3'b000; req_addr[23:16] = 8'h05;
        tick();
        chk("rw_grant2", grant_id, 2);
        tick();
        chk("rw_strobe", reg_rd, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rw_rd", reg_rd, 0);
        chk("rw_rdata", rdata, 0);
        chk("rw_busy", busy, 0);
        chk("rw_ack", ack, 0);
        chk("rw_grant", grant_id, 2);
        chk("rw_addr", reg_addr, 0);
        tick();
        chk("rw_ack_held", ack, 0);
        req = 3'b101;
        rst = 1'b0;
        tick();
        chk("rw_first_grant", grant_id, 0);
        tick();
        chk("rw_first_rd", reg_rd, 1);
        tick();
        tick();
        chk("rw_first_ack", ack, 3'b001);
        req = 3'b000;
        tick();

        // READ_LAT=0 instance, read of 0xFF
        req_z = 3'b001; req_wr_z = 3'b000; req_addr_z[7:0] = 8'hFF;
        tick();
        chk("z_c1_busy", busy_z, 1);
        tick();
        chk("z_c2_rd", reg_rd_z, 1);
        chk("z_c2_rdata", rdata_z, 0);
        chk("z_c2_ack", ack_z, 0);
        tick();
        chk("z_c3_ack", ack_z, 3'b001);
        chk("z_c3_rdata", rdata_z, 8'h81);
        req_z = 3'b000;
        tick();
        chk("z_c4_ack", ack_z, 0);
        chk("z_c4_busy", busy_z, 0);
        chk("z_c4_rdata", rdata_z, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
